// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: tracks E/M writers (dest, Tnew)
// and the mult/div busy counter, and derives stall, pipeline-register enables and D forwarding.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       en_PC,
  output logic       en_FD,
  output logic       clr_DE,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic       md_busy
);

  localparam int unsigned MaxCyc = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [4:0]      r_wa_E, r_wa_M;
  logic [1:0]      r_tnew_E, r_tnew_M;
  logic [CntW-1:0] r_md_cnt;

  logic w_rs_hz, w_rt_hz, w_md_hz;

  // The youngest writer of a register decides; an older M entry is ignored once E matches.
  function automatic logic f_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] wa_e, input logic [1:0] tnew_e,
                                    input logic [4:0] wa_m, input logic [1:0] tnew_m);
    logic hz;
    hz = 1'b0;
    if (src != 5'd0 && tuse != 2'd3) begin
      if (src == wa_e)      hz = (tnew_e > tuse);
      else if (src == wa_m) hz = (tnew_m > tuse);
    end
    return hz;
  endfunction

  function automatic logic [1:0] f_fwd(input logic [4:0] src,
                                       input logic [4:0] wa_e, input logic [1:0] tnew_e,
                                       input logic [4:0] wa_m, input logic [1:0] tnew_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if (src == wa_e && tnew_e == 2'd0)      sel = 2'd1;
      else if (src == wa_m && tnew_m == 2'd0) sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    md_busy  = (r_md_cnt != '0);
    w_md_hz  = md_use_D && md_busy;
    w_rs_hz  = f_hazard(rs_D, tuse_rs_D, r_wa_E, r_tnew_E, r_wa_M, r_tnew_M);
    w_rt_hz  = f_hazard(rt_D, tuse_rt_D, r_wa_E, r_tnew_E, r_wa_M, r_tnew_M);
    stall    = w_rs_hz || w_rt_hz || w_md_hz;
    en_PC    = ~stall;
    en_FD    = ~stall;
    clr_DE   = stall;
    fwd_rs_D = f_fwd(rs_D, r_wa_E, r_tnew_E, r_wa_M, r_tnew_M);
    fwd_rt_D = f_fwd(rt_D, r_wa_E, r_tnew_E, r_wa_M, r_tnew_M);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wa_E   <= 5'd0;
      r_tnew_E <= 2'd0;
      r_wa_M   <= 5'd0;
      r_tnew_M <= 2'd0;
    end else begin
      if (stall) begin
        r_wa_E   <= 5'd0;
        r_tnew_E <= 2'd0;
      end else begin
        r_wa_E   <= wa_D;
        r_tnew_E <= tnew_D;
      end
      r_wa_M   <= r_wa_E;
      r_tnew_M <= (r_tnew_E == 2'd0) ? 2'd0 : r_tnew_E - 2'd1;
    end
  end

  // A new mult/div issue reloads the counter even if it is still counting down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (!stall && md_start_D) begin
      r_md_cnt <= md_div_D ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CntW'(1);
    end
  end

endmodule
